surf_dac_sequencer: RTL and testbench

Owns the 32-channel DAC shadow memory and serially loads it into the external DAC chain when the host requests an update. It sits between the host bus interface, which supplies write strobe/address/data, update pulse and readback, and the DAC serial pins. It converts a one-cycle `update` request into a complete, framed load of all channels followed by a latch pulse, and reports `busy` for the whole sequence.

---
 rtl/surf_dac_sequencer_if.sv | 13 +
 rtl/surf_dac_sequencer.sv | 93 +++++++++
 tb/tb_surf_dac_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/surf_dac_sequencer_if.sv
// Host-side bus of the DAC sequencer: shadow write/readback plus the update/busy handshake.
interface surf_dac_sequencer_if;
    logic        wr_i;
    logic [4:0]  waddr_i;
    logic [15:0] dat_i;
    logic [4:0]  raddr_i;
    logic [15:0] dat_o;
    logic        update_i;
    logic        busy_o;

    modport master (output wr_i, waddr_i, dat_i, raddr_i, update_i, input dat_o, busy_o);
    modport slave  (input wr_i, waddr_i, dat_i, raddr_i, update_i, output dat_o, busy_o);
endinterface

// File: rtl/surf_dac_sequencer.sv
// DAC shadow memory and serial loader: on update, frames every channel out MSB first,
// then pulses nLDAC; further updates during a load collapse into one rerun.
module surf_dac_sequencer #(
    parameter int NCHAN  = 32,
    parameter int CLKDIV = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    surf_dac_sequencer_if.slave  host,
    output logic                 dac_sclk_o,
    output logic                 dac_din_o,
    output logic                 dac_ncs_o,
    output logic                 dac_nldac_o
);
    localparam int CW = $clog2(2 * CLKDIV + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, LDAC} state_t;

    state_t        state, state_n;
    logic [15:0]   shadow [NCHAN];
    logic [CW-1:0] cnt, lim;
    logic          cnt_last, sclk_n, pending;
    logic [4:0]    bit_idx, ch;
    logic [23:0]   sreg;

    // Power-up contents come from the configuration image (all zero); rst_i never touches them.
    always_ff @(posedge clk_i) begin
        if (host.wr_i) shadow[host.waddr_i] <= host.dat_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) host.dat_o <= '0;
        else       host.dat_o <= shadow[host.raddr_i];
    end

    always_comb begin
        lim      = (state == LDAC) ? CW'(2 * CLKDIV - 1) : CW'(CLKDIV - 1);
        cnt_last = (cnt == lim);
        state_n  = state;
        sclk_n   = 1'b0;
        case (state)
            IDLE:  if (host.update_i) state_n = LOAD;
            LOAD:  state_n = SHIFT;
            SHIFT: begin
                sclk_n = cnt_last ? ~dac_sclk_o : dac_sclk_o;
                if (cnt_last && dac_sclk_o && bit_idx == 5'd0) state_n = GAP;
            end
            GAP:   if (cnt_last) state_n = (ch == 5'(NCHAN - 1)) ? LDAC : LOAD;
            // A request landing on the final LDAC cycle still counts as a rerun.
            LDAC:  if (cnt_last) state_n = (pending || host.update_i) ? LOAD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            ch          <= '0;
            sreg        <= '0;
            pending     <= 1'b0;
            dac_sclk_o  <= 1'b0;
            dac_ncs_o   <= 1'b1;
            dac_nldac_o <= 1'b1;
        end else begin
            state       <= state_n;
            dac_sclk_o  <= sclk_n;
            dac_ncs_o   <= (state_n != SHIFT);
            dac_nldac_o <= (state_n != LDAC);

            if (state == IDLE || state_n != state || cnt_last) cnt <= '0;
            else                                             cnt <= cnt + 1'b1;

            // LOAD reads the pre-write shadow value when a write hits the same channel.
            if (state == LOAD) begin
                sreg    <= {3'b000, ch, shadow[ch]};
                bit_idx <= 5'd23;
            end else if (state == SHIFT && cnt_last && dac_sclk_o) begin
                sreg    <= {sreg[22:0], 1'b0};
                bit_idx <= bit_idx - 1'b1;
            end

            if (state_n == LOAD) ch <= (state == GAP) ? ch + 1'b1 : 5'd0;

            if (state == LDAC && state_n != LDAC)    pending <= 1'b0;
            else if (state != IDLE && host.update_i) pending <= 1'b1;
        end
    end

    assign dac_din_o   = sreg[23];
    assign host.busy_o = (state != IDLE);
endmodule

// File: tb/tb_surf_dac_sequencer.sv
// Scoreboard bench: a CLKDIV=4 and a CLKDIV=1 sequencer share shadow writes; SPI frames,
// busy lengths and nLDAC pulses are checked against a channel-array model.
module tb_surf_dac_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    surf_dac_sequencer_if h0 ();
    surf_dac_sequencer_if h1 ();

    logic       upd1;
    logic [1:0] sclk, din, ncs, nldac, busy;
    logic [15:0] sh [32];
    int total = 0, bad = 0;
    int ld_exp [2] = '{0, 0};

    assign h1.wr_i     = h0.wr_i;
    assign h1.waddr_i  = h0.waddr_i;
    assign h1.dat_i    = h0.dat_i;
    assign h1.raddr_i  = h0.raddr_i;
    assign h1.update_i = upd1;
    assign busy[0]     = h0.busy_o;
    assign busy[1]     = h1.busy_o;

    surf_dac_sequencer #(.NCHAN(32), .CLKDIV(4)) dut0 (
        .clk_i(clk), .rst_i(rst), .host(h0),
        .dac_sclk_o(sclk[0]), .dac_din_o(din[0]), .dac_ncs_o(ncs[0]), .dac_nldac_o(nldac[0]));

    surf_dac_sequencer #(.NCHAN(32), .CLKDIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .host(h1),
        .dac_sclk_o(sclk[1]), .dac_din_o(din[1]), .dac_ncs_o(ncs[1]), .dac_nldac_o(nldac[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_mon
        localparam int CD = (k == 0) ? 4 : 1;
        logic [23:0] exp_q [$];
        int          busy_q [$];
        logic [23:0] acc = '0;
        int nb = 0, nfr = 0, nld = 0, bcnt = 0, lcnt = 0, hcnt = 0, locnt = 0;

        always @(negedge ncs[k]) nb = 0;

        always @(posedge sclk[k]) begin
            acc = {acc[22:0], din[k]};
            nb++;
            if (nb == 24) begin
                nb = 0;
                nfr++;
                if (exp_q.size() == 0) check($sformatf("frame_extra%0d", k), exp_q.size(), 1);
                else                   check($sformatf("frame%0d", k), acc, exp_q.pop_front());
            end
        end

        always @(negedge clk) begin
            if (rst) begin
                bcnt = 0; lcnt = 0; hcnt = 0; locnt = 0;
            end else begin
                if (busy[k]) bcnt++;
                else if (bcnt > 0) begin
                    if (busy_q.size() == 0) check($sformatf("busy_extra%0d", k), busy_q.size(), 1);
                    else                    check($sformatf("busy_len%0d", k), bcnt, busy_q.pop_front());
                    bcnt = 0;
                end
                if (!nldac[k]) lcnt++;
                else if (lcnt > 0) begin
                    check($sformatf("ldac_len%0d", k), lcnt, 2 * CD);
                    nld++;
                    lcnt = 0;
                end
                if (sclk[k]) hcnt++;
                else if (hcnt > 0) begin
                    check($sformatf("sclk_hi%0d", k), hcnt, CD);
                    hcnt = 0;
                end
                if (!ncs[k] && !sclk[k]) locnt++;
                else if (locnt > 0) begin
                    check($sformatf("sclk_lo%0d", k), locnt, CD);
                    locnt = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [15:0] v);
        h0.wr_i = 1'b1; h0.waddr_i = 5'(a); h0.dat_i = v;
        sh[a] = v;
        tick(1);
        h0.wr_i = 1'b0;
    endtask

    // Expected frames for one full load, from the model's current shadow contents.
    task automatic push_run(input int k, input int busy_len);
        for (int c = 0; c < 32; c++) begin
            if (k == 0) g_mon[0].exp_q.push_back({3'b000, 5'(c), sh[c]});
            else        g_mon[1].exp_q.push_back({3'b000, 5'(c), sh[c]});
        end
        if (busy_len > 0) begin
            if (k == 0) g_mon[0].busy_q.push_back(busy_len);
            else        g_mon[1].busy_q.push_back(busy_len);
        end
        ld_exp[k]++;
    endtask

    // A write during a run reaches every channel not yet loaded (queue head is in flight).
    task automatic patch(input int a);
        logic [23:0] f;
        for (int i = 1; i < g_mon[0].exp_q.size(); i++) begin
            f = g_mon[0].exp_q[i];
            if (f[20:16] == 5'(a)) begin
                f[15:0] = sh[a];
                g_mon[0].exp_q[i] = f;
            end
        end
    endtask

    task automatic pulse(input int k);
        if (k == 0) h0.update_i = 1'b1; else upd1 = 1'b1;
        tick(1);
        if (k == 0) h0.update_i = 1'b0; else upd1 = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int limit);
        int n = 0;
        while (busy[k] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("idle_timeout%0d", k), busy[k], 1'b0);
        tick(2);
    endtask

    task automatic wait_ch(input int target, input int limit);
        int n = 0;
        while (!(g_mon[0].nfr == target && ncs[0] == 1'b0) && n < limit) begin
            tick(1);
            n++;
        end
        check("wait_ch_timeout", (n < limit), 1'b1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a, base;
        h0.wr_i = 1'b0; h0.waddr_i = '0; h0.dat_i = '0; h0.raddr_i = '0; h0.update_i = 1'b0;
        upd1 = 1'b0;
        for (int c = 0; c < 32; c++) sh[c] = '0;

        tick(3);
        check("rst_busy",  busy[0],  1'b0);
        check("rst_sclk",  sclk[0],  1'b0);
        check("rst_din",   din[0],   1'b0);
        check("rst_ncs",   ncs[0],   1'b1);
        check("rst_nldac", nldac[0], 1'b1);
        check("rst_dat",   h0.dat_o, 16'h0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(0, 31);
            h0.raddr_i = 5'(a);
            tick(1);
            check("cfg_zero", h0.dat_o, 16'h0);
        end
        wr(5, 16'hA5C3);
        h0.raddr_i = 5'd5;
        tick(1);
        check("readback5", h0.dat_o, 16'hA5C3);
        check("readback5_d1", h1.dat_o, 16'hA5C3);

        // Ramp pattern, single load on both builds.
        for (int c = 0; c < 32; c++) wr(c, 16'(16'h1000 + c));
        push_run(0, 6312);
        pulse(0);
        wait_idle(0, 8000);
        push_run(1, 1602);
        pulse(1);
        wait_idle(1, 3000);

        // Three requests during busy collapse into one back-to-back rerun.
        push_run(0, 12624);
        push_run(0, 0);
        pulse(0);
        for (int i = 0; i < 3; i++) begin
            tick($urandom_range(1, 1990));
            pulse(0);
        end
        wait_idle(0, 14000);

        // Writes during channel 3: channel 31 picks up the new value, channel 0 does not.
        for (int c = 0; c < 32; c++) wr(c, 16'($urandom));
        push_run(0, 6312);
        base = g_mon[0].nfr;
        pulse(0);
        wait_ch(base + 3, 2000);
        wr(31, 16'hFFFF);
        patch(31);
        wr(0, 16'($urandom));
        patch(0);
        wait_idle(0, 8000);
        push_run(0, 6312);
        pulse(0);
        wait_idle(0, 8000);

        // Reset during channel 10 with a rerun pending: sequence and pending are dropped.
        push_run(0, 0);
        ld_exp[0]--;
        base = g_mon[0].nfr;
        pulse(0);
        wait_ch(base + 10, 3000);
        pulse(0);
        tick($urandom_range(0, 100));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ncs",   ncs[0],   1'b1);
        check("midrst_sclk",  sclk[0],  1'b0);
        check("midrst_busy",  busy[0],  1'b0);
        check("midrst_nldac", nldac[0], 1'b1);
        tick(2);
        rst = 1'b0;
        check("midrst_frames", g_mon[0].exp_q.size(), 22);
        g_mon[0].exp_q.delete();
        h0.raddr_i = 5'd31;
        tick(1);
        check("rst_keep31", h0.dat_o, sh[31]);
        h0.raddr_i = 5'd0;
        tick(1);
        check("rst_keep0", h0.dat_o, sh[0]);
        push_run(0, 6312);
        pulse(0);
        wait_idle(0, 8000);

        // CLKDIV=1: request coincident with the final LDAC cycle reruns.
        push_run(1, 3204);
        push_run(1, 0);
        pulse(1);
        tick(1601);
        upd1 = 1'b1;
        tick(1);
        upd1 = 1'b0;
        wait_idle(1, 4000);

        tick(5);
        check("left_frames0", g_mon[0].exp_q.size(), 0);
        check("left_frames1", g_mon[1].exp_q.size(), 0);
        check("left_busy0",   g_mon[0].busy_q.size(), 0);
        check("left_busy1",   g_mon[1].busy_q.size(), 0);
        check("ldac_count0",  g_mon[0].nld, ld_exp[0]);
        check("ldac_count1",  g_mon[1].nld, ld_exp[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
